// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store unit with lane shifting, extension and split beats
//
// Purpose: accepts one load/store request at a time over a valid/ready handshake,
// issues one or two word-aligned memory beats, and returns a one-cycle response.
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_req_valid / o_req_ready      request handshake (ready only while idle)
//   i_req_we, i_req_funct3         store flag, RISC-V funct3 (size / zero-extend)
//   i_req_addr, i_req_wdata        byte address, LSB-aligned store data
//   o_rsp_valid, o_rsp_rdata       completion pulse, extended load data
//   o_rsp_fault                    illegal funct3 or disallowed misalignment
//   o_mem_req/_we/_addr/_be/_wdata memory beat, held until i_mem_ack
//   i_mem_ack, i_mem_rdata         beat completion, read word valid with ack
module load_store_unit #(
    parameter int XLEN               = 32,
    parameter int ADDR_W             = 32,
    parameter int SUPPORT_MISALIGNED = 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_req_valid,
    output logic                o_req_ready,
    input  logic                i_req_we,
    input  logic [2:0]          i_req_funct3,
    input  logic [ADDR_W-1:0]   i_req_addr,
    input  logic [XLEN-1:0]     i_req_wdata,
    output logic                o_rsp_valid,
    output logic [XLEN-1:0]     o_rsp_rdata,
    output logic                o_rsp_fault,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [XLEN/8-1:0]   o_mem_be,
    output logic [XLEN-1:0]     o_mem_wdata,
    input  logic                i_mem_ack,
    input  logic [XLEN-1:0]     i_mem_rdata
);

    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    // Wide enough for size (up to 8) plus offset (up to NB-1).
    localparam int SW   = OFFW + 2;

    typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_RESP} state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_we;
    logic [2:0]          r_funct3;
    logic [ADDR_W-1:0]   r_addr;
    logic [XLEN-1:0]     r_wdata;
    logic                r_fault;
    logic                r_cross;
    logic [XLEN-1:0]     r_rd0;
    logic [XLEN-1:0]     r_rd1;

    // Request decode, evaluated on the raw inputs at accept time.
    logic [SW-1:0]       w_in_off;
    logic [SW-1:0]       w_in_size;
    logic                w_in_illegal;
    logic                w_in_misal;
    logic                w_in_cross;
    logic                w_in_fault;
    logic                w_accept;

    assign w_accept     = (r_state == S_IDLE) && i_req_valid;
    assign w_in_off     = SW'(i_req_addr[OFFW-1:0]);
    assign w_in_size    = SW'(1) << i_req_funct3[1:0];
    assign w_in_illegal = (w_in_size > SW'(NB))
                        | (i_req_we & i_req_funct3[2])
                        | (!i_req_we && i_req_funct3 == 3'b111)
                        | (!i_req_we && (XLEN == 32) && i_req_funct3 == 3'b110);
    assign w_in_misal   = (w_in_off & (w_in_size - SW'(1))) != '0;
    assign w_in_cross   = (w_in_off + w_in_size) > SW'(NB);
    assign w_in_fault   = w_in_illegal | ((SUPPORT_MISALIGNED == 0) & w_in_misal);

    // Datapath on the latched request. The double-width vectors hold both beats:
    // lower half is beat 0, upper half is the spill into beat 1.
    logic [OFFW-1:0]     w_off;
    logic [SW-1:0]       w_size;
    logic [2*NB-1:0]     w_be_full;
    logic [2*XLEN-1:0]   w_wd_full;
    logic [XLEN-1:0]     w_rd_low;
    logic [XLEN-1:0]     w_size_mask;
    logic                w_sign;
    logic [XLEN-1:0]     w_ext;
    logic [ADDR_W-1:0]   w_word_addr;

    assign w_off       = r_addr[OFFW-1:0];
    assign w_size      = SW'(1) << r_funct3[1:0];
    assign w_be_full   = (((2*NB)'(1) << w_size) - (2*NB)'(1)) << w_off;
    assign w_wd_full   = {{XLEN{1'b0}}, r_wdata} << {w_off, 3'b000};
    assign w_rd_low    = XLEN'({r_rd1, r_rd0} >> {w_off, 3'b000});
    // A full-width access shifts the 1 out, leaving an all-ones mask.
    assign w_size_mask = (XLEN'(1) << {w_size, 3'b000}) - XLEN'(1);
    assign w_word_addr = {r_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};

    always_comb begin
        w_sign = 1'b0;
        case (r_funct3[1:0])
            2'd0:    w_sign = w_rd_low[7];
            2'd1:    w_sign = w_rd_low[15];
            2'd2:    w_sign = w_rd_low[31];
            default: w_sign = w_rd_low[XLEN-1];
        endcase
        w_ext = (w_rd_low & w_size_mask)
              | ((w_sign && !r_funct3[2]) ? ~w_size_mask : '0);
    end

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Request latch and read-beat capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_fault  <= 1'b0;
            r_cross  <= 1'b0;
            r_rd0    <= '0;
            r_rd1    <= '0;
        end else begin
            if (w_accept) begin
                r_we     <= i_req_we;
                r_funct3 <= i_req_funct3;
                r_addr   <= i_req_addr;
                r_wdata  <= i_req_wdata;
                r_fault  <= w_in_fault;
                r_cross  <= w_in_cross;
                r_rd0    <= '0;
                r_rd1    <= '0;
            end
            if (r_state == S_BEAT0 && i_mem_ack) r_rd0 <= i_mem_rdata;
            if (r_state == S_BEAT1 && i_mem_ack) r_rd1 <= i_mem_rdata;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_req_valid) w_next = w_in_fault ? S_RESP : S_BEAT0;
            S_BEAT0: if (i_mem_ack)   w_next = r_cross ? S_BEAT1 : S_RESP;
            S_BEAT1: if (i_mem_ack)   w_next = S_RESP;
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic; everything is zero outside the state that owns it.
    always_comb begin
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        o_rsp_rdata = '0;
        o_rsp_fault = 1'b0;
        o_mem_req   = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_be    = '0;
        o_mem_wdata = '0;
        case (r_state)
            S_IDLE: o_req_ready = 1'b1;
            S_BEAT0: begin
                o_mem_req   = 1'b1;
                o_mem_we    = r_we;
                o_mem_addr  = w_word_addr;
                o_mem_be    = w_be_full[NB-1:0];
                o_mem_wdata = w_wd_full[XLEN-1:0];
            end
            S_BEAT1: begin
                o_mem_req   = 1'b1;
                o_mem_we    = r_we;
                o_mem_addr  = w_word_addr + ADDR_W'(NB);
                o_mem_be    = w_be_full[2*NB-1:NB];
                o_mem_wdata = w_wd_full[2*XLEN-1:XLEN];
            end
            default: begin
                o_rsp_valid = 1'b1;
                o_rsp_fault = r_fault;
                o_rsp_rdata = (r_we || r_fault) ? '0 : w_ext;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        i_req_valid1 = 1'b0;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = '0;
    logic [31:0] i_req_addr = '0;
    logic [31:0] i_req_wdata = '0;
    logic        i_mem_ack = 1'b0;
    logic [31:0] i_mem_rdata = '0;

    logic        o_req_ready, o_rsp_valid, o_rsp_fault, o_mem_req, o_mem_we;
    logic [31:0] o_rsp_rdata, o_mem_addr, o_mem_wdata;
    logic [3:0]  o_mem_be;

    logic        o_req_ready1, o_rsp_valid1, o_rsp_fault1, o_mem_req1, o_mem_we1;
    logic [31:0] o_rsp_rdata1, o_mem_addr1, o_mem_wdata1;
    logic [3:0]  o_mem_be1;
    logic        w_mem_ack1;
    logic [31:0] w_mem_rdata1;

    assign w_mem_ack1   = o_mem_req1;
    assign w_mem_rdata1 = 32'h1357_9BDF;

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    load_store_unit #(.XLEN(32), .ADDR_W(32), .SUPPORT_MISALIGNED(1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_fault(o_rsp_fault),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    load_store_unit #(.XLEN(32), .ADDR_W(32), .SUPPORT_MISALIGNED(0)) dut_strict (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_req_valid(i_req_valid1), .o_req_ready(o_req_ready1),
        .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid1), .o_rsp_rdata(o_rsp_rdata1), .o_rsp_fault(o_rsp_fault1),
        .o_mem_req(o_mem_req1), .o_mem_we(o_mem_we1), .o_mem_addr(o_mem_addr1),
        .o_mem_be(o_mem_be1), .o_mem_wdata(o_mem_wdata1),
        .i_mem_ack(w_mem_ack1), .i_mem_rdata(w_mem_rdata1)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd0;
        logic [31:0] rd1;
        int          beats;
        int          delay;
        logic [31:0] a0;
        logic [3:0]  be0;
        logic [3:0]  be1;
        logic [31:0] wd0;
        logic [31:0] wd1;
        logic [31:0] rdata;
        logic        fault;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          lat;
        int          acc;
    } exp_t;

    vec_t vecs[17];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        exp_t e;
        int   n;
        chk($sformatf("v%0d_ready_idle", idx), {31'b0, o_req_ready}, 32'd1);
        i_req_we     = v.we;
        i_req_funct3 = v.f3;
        i_req_addr   = v.addr;
        i_req_wdata  = v.wdata;
        i_req_valid  = 1'b1;
        sb.push_back('{v.rdata, v.fault, v.fault ? 1 : 1 + v.beats * (1 + v.delay), cyc});
        step();
        i_req_valid = 1'b0;
        for (int b = 0; b < v.beats; b++) begin
            for (int w = 0; w <= v.delay; w++) begin
                chk($sformatf("v%0d_b%0d_mem_req", idx, b), {31'b0, o_mem_req}, 32'd1);
                chk($sformatf("v%0d_b%0d_req_ready", idx, b), {31'b0, o_req_ready}, 32'd0);
                chk($sformatf("v%0d_b%0d_mem_we", idx, b), {31'b0, o_mem_we}, {31'b0, v.we});
                chk($sformatf("v%0d_b%0d_mem_addr", idx, b), o_mem_addr, v.a0 + 32'(4 * b));
                chk($sformatf("v%0d_b%0d_mem_be", idx, b), {28'b0, o_mem_be}, {28'b0, (b == 0) ? v.be0 : v.be1});
                chk($sformatf("v%0d_b%0d_mem_wdata", idx, b), o_mem_wdata, (b == 0) ? v.wd0 : v.wd1);
                if (w == v.delay) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = (b == 0) ? v.rd0 : v.rd1;
                end
                step();
                i_mem_ack   = 1'b0;
                i_mem_rdata = 32'hDEAD_0000;
            end
        end
        n = 0;
        while (!o_rsp_valid && n < 8) begin
            step();
            n++;
        end
        if (!o_rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL v%0d_rsp_timeout actual=no_rsp expected=rsp_valid", idx);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_rsp_mem_req", idx), {31'b0, o_mem_req}, 32'd0);
            chk($sformatf("v%0d_rsp_rdata", idx), o_rsp_rdata, e.rdata);
            chk($sformatf("v%0d_rsp_fault", idx), {31'b0, o_rsp_fault}, {31'b0, e.fault});
            chk($sformatf("v%0d_latency", idx), 32'(cyc - e.acc), 32'(e.lat));
            step();
            chk($sformatf("v%0d_rsp_pulse", idx), {31'b0, o_rsp_valid}, 32'd0);
            chk($sformatf("v%0d_ready_after", idx), {31'b0, o_req_ready}, 32'd1);
        end
    endtask

    initial begin
        //          we  f3      addr         wdata         rd0           rd1          bt dl a0           be0      be1      wd0           wd1           rdata         fault
        vecs[0]  = '{0, 3'b000, 32'h103, 32'h0,        32'h8022_3344, 32'h0,        1, 0, 32'h100, 4'b1000, 4'b0000, 32'h0,        32'h0,        32'hFFFF_FF80, 0};
        vecs[1]  = '{0, 3'b101, 32'h102, 32'h0,        32'hBEEF_1234, 32'h0,        1, 0, 32'h100, 4'b1100, 4'b0000, 32'h0,        32'h0,        32'h0000_BEEF, 0};
        vecs[2]  = '{1, 3'b000, 32'h101, 32'hA5,       32'h0,         32'h0,        1, 0, 32'h100, 4'b0010, 4'b0000, 32'h0000_A500, 32'h0,        32'h0,         0};
        vecs[3]  = '{0, 3'b010, 32'h103, 32'h0,        32'h1122_3344, 32'h5566_7788, 2, 0, 32'h100, 4'b1000, 4'b0111, 32'h0,        32'h0,        32'h6677_8811, 0};
        vecs[4]  = '{1, 3'b010, 32'h102, 32'hDEAD_BEEF, 32'h0,        32'h0,        2, 0, 32'h100, 4'b1100, 4'b0011, 32'hBEEF_0000, 32'h0000_DEAD, 32'h0,        0};
        vecs[5]  = '{0, 3'b011, 32'h100, 32'h0,        32'h0,         32'h0,        0, 0, 32'h0,   4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,         1};
        vecs[6]  = '{0, 3'b001, 32'h101, 32'h0,        32'h1280_0144, 32'h0,        1, 0, 32'h100, 4'b0110, 4'b0000, 32'h0,        32'h0,        32'hFFFF_8001, 0};
        vecs[7]  = '{0, 3'b001, 32'h103, 32'h0,        32'hAB00_0000, 32'h0000_00CD, 2, 0, 32'h100, 4'b1000, 4'b0001, 32'h0,        32'h0,        32'hFFFF_CDAB, 0};
        vecs[8]  = '{0, 3'b100, 32'h200, 32'h0,        32'h0000_00F0, 32'h0,        1, 0, 32'h200, 4'b0001, 4'b0000, 32'h0,        32'h0,        32'h0000_00F0, 0};
        vecs[9]  = '{0, 3'b110, 32'h100, 32'h0,        32'h0,         32'h0,        0, 0, 32'h0,   4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,         1};
        vecs[10] = '{1, 3'b100, 32'h100, 32'h55,       32'h0,         32'h0,        0, 0, 32'h0,   4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,         1};
        vecs[11] = '{1, 3'b001, 32'h103, 32'h1234,     32'h0,         32'h0,        2, 0, 32'h100, 4'b1000, 4'b0001, 32'h3400_0000, 32'h0000_0012, 32'h0,        0};
        vecs[12] = '{0, 3'b111, 32'h100, 32'h0,        32'h0,         32'h0,        0, 0, 32'h0,   4'b0000, 4'b0000, 32'h0,        32'h0,        32'h0,         1};
        vecs[13] = '{0, 3'b000, 32'h100, 32'h0,        32'h0000_007F, 32'h0,        1, 0, 32'h100, 4'b0001, 4'b0000, 32'h0,        32'h0,        32'h0000_007F, 0};
        vecs[14] = '{0, 3'b010, 32'h104, 32'h0,        32'hCAFE_F00D, 32'h0,        1, 3, 32'h104, 4'b1111, 4'b0000, 32'h0,        32'h0,        32'hCAFE_F00D, 0};
        vecs[15] = '{0, 3'b010, 32'h102, 32'h0,        32'h5678_AAAA, 32'hBBBB_1234, 2, 1, 32'h100, 4'b1100, 4'b0011, 32'h0,        32'h0,        32'h1234_5678, 0};
        vecs[16] = '{1, 3'b001, 32'h102, 32'hBEEF,     32'h0,         32'h0,        1, 0, 32'h100, 4'b1100, 4'b0000, 32'hBEEF_0000, 32'h0,        32'h0,         0};

        // Reset state
        step();
        step();
        chk("rst_req_ready", {31'b0, o_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
        chk("rst_rsp_fault", {31'b0, o_rsp_fault}, 32'd0);
        chk("rst_mem_req", {31'b0, o_mem_req}, 32'd0);
        chk("rst_mem_we", {31'b0, o_mem_we}, 32'd0);
        chk("rst_mem_addr", o_mem_addr, 32'h0);
        chk("rst_mem_be", {28'b0, o_mem_be}, 32'h0);
        chk("rst_mem_wdata", o_mem_wdata, 32'h0);
        chk("rst_rsp_rdata", o_rsp_rdata, 32'h0);
        i_rst_n = 1'b1;
        step();

        for (int i = 0; i < 17; i++) run_vec(vecs[i], i);

        // Strict instance: misaligned halfword faults without a beat, response at N+1.
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b001;
        i_req_addr   = 32'h101;
        i_req_valid1 = 1'b1;
        step();
        i_req_valid1 = 1'b0;
        chk("strict_lh_rsp_valid", {31'b0, o_rsp_valid1}, 32'd1);
        chk("strict_lh_fault", {31'b0, o_rsp_fault1}, 32'd1);
        chk("strict_lh_no_mem", {31'b0, o_mem_req1}, 32'd0);
        chk("strict_lh_rdata", o_rsp_rdata1, 32'h0);
        step();
        chk("strict_lh_ready", {31'b0, o_req_ready1}, 32'd1);

        // Strict instance: aligned word still performs one beat.
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h104;
        i_req_valid1 = 1'b1;
        step();
        i_req_valid1 = 1'b0;
        chk("strict_lw_mem_req", {31'b0, o_mem_req1}, 32'd1);
        chk("strict_lw_mem_addr", o_mem_addr1, 32'h104);
        step();
        chk("strict_lw_rsp_valid", {31'b0, o_rsp_valid1}, 32'd1);
        chk("strict_lw_rdata", o_rsp_rdata1, 32'h1357_9BDF);
        chk("strict_lw_fault", {31'b0, o_rsp_fault1}, 32'd0);
        step();

        // Reset asserted while the second beat of a crossing load is outstanding.
        i_req_we     = 1'b0;
        i_req_funct3 = 3'b010;
        i_req_addr   = 32'h103;
        i_req_valid  = 1'b1;
        step();
        i_req_valid = 1'b0;
        i_mem_ack   = 1'b1;
        i_mem_rdata = 32'h1111_1111;
        step();
        i_mem_ack = 1'b0;
        chk("rstmid_beat1_req", {31'b0, o_mem_req}, 32'd1);
        chk("rstmid_beat1_addr", o_mem_addr, 32'h104);
        #2 i_rst_n = 1'b0;
        #1;
        chk("rstmid_mem_req", {31'b0, o_mem_req}, 32'd0);
        chk("rstmid_req_ready", {31'b0, o_req_ready}, 32'd1);
        chk("rstmid_mem_be", {28'b0, o_mem_be}, 32'h0);
        step();
        i_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("rstmid_no_rsp_%0d", k), {31'b0, o_rsp_valid}, 32'd0);
            chk($sformatf("rstmid_idle_%0d", k), {31'b0, o_req_ready}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
